// File: rtl/video_timing_gen_if.sv
// Raster timing bus between video_timing_gen (master) and the DVI encoder / pixel FIFO side (slave).
// comp_sync is present only when VTG_CSYNC_EN is defined.
interface video_timing_gen_if #(
  parameter int CW = 10
);
  logic          enable;
  logic          hsync;
  logic          vsync;
  logic          blank;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          pix_req;
  logic          line_start;
  logic          frame_start;
`ifdef VTG_CSYNC_EN
  logic          comp_sync;
`endif

  modport master (
`ifdef VTG_CSYNC_EN
    output comp_sync,
`endif
    input  enable,
    output hsync, vsync, blank, pixel_x, pixel_y, pix_req, line_start, frame_start
  );

  modport slave (
`ifdef VTG_CSYNC_EN
    input  comp_sync,
`endif
    output enable,
    input  hsync, vsync, blank, pixel_x, pixel_y, pix_req, line_start, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with programmable pix_req lookahead.
// Optional composite sync output enabled by defining VTG_CSYNC_EN.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int PREFETCH = 2
) (
  input logic               clk,
  input logic               rst,
  video_timing_gen_if.master vt
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  function automatic logic in_win(input int x, input int lo, input int hi);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic pol_level(input logic act, input logic pol);
    return act ? pol : ~pol;
  endfunction

  logic [CW-1:0] h_p0, v_p0;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          hsync_p0, vsync_p0, blank_p0, pix_req_p0;
  logic          line_start_p0, frame_start_p0;
  logic          hs_act_nxt, vs_act_nxt, blank_nxt, pix_req_nxt;
  int            h_la, v_la;

  always_comb begin
    h_nxt = h_p0 + 1'b1;
    v_nxt = v_p0;
    if (h_p0 == CW'(H_TOTAL - 1)) begin
      h_nxt = '0;
      v_nxt = (v_p0 == CW'(V_TOTAL - 1)) ? '0 : v_p0 + 1'b1;
    end
  end

  // Outputs are decoded from the next position so they line up with pixel_x/pixel_y once registered.
  always_comb begin
    hs_act_nxt = in_win(int'(h_nxt), HS_START, HS_END);
    vs_act_nxt = in_win(int'(v_nxt), VS_START, VS_END);
    blank_nxt  = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
    h_la       = int'(h_nxt) + PREFETCH;
    v_la       = int'(v_nxt);
    if (h_la >= H_TOTAL) begin
      h_la = h_la - H_TOTAL;
      v_la = (v_la == V_TOTAL - 1) ? 0 : v_la + 1;
    end
    pix_req_nxt = (h_la < H_ACTIVE) && (v_la < V_ACTIVE);
  end

  // ---- stage p0: raster position and registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_p0           <= CW'(H_ACTIVE);
      v_p0           <= CW'(V_TOTAL - 1);
      hsync_p0       <= ~HS_POL;
      vsync_p0       <= ~VS_POL;
      blank_p0       <= 1'b0;
      pix_req_p0     <= 1'b0;
      line_start_p0  <= 1'b0;
      frame_start_p0 <= 1'b0;
    end else if (vt.enable) begin
      h_p0           <= h_nxt;
      v_p0           <= v_nxt;
      hsync_p0       <= pol_level(hs_act_nxt, HS_POL);
      vsync_p0       <= pol_level(vs_act_nxt, VS_POL);
      blank_p0       <= blank_nxt;
      pix_req_p0     <= pix_req_nxt;
      line_start_p0  <= (h_nxt == '0);
      frame_start_p0 <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

`ifdef VTG_CSYNC_EN
  logic comp_sync_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_sync_p0 <= ~HS_POL;
    end else if (vt.enable) begin
      comp_sync_p0 <= pol_level(hs_act_nxt ^ vs_act_nxt, HS_POL);
    end
  end

  assign vt.comp_sync = comp_sync_p0;
`endif

  assign vt.pixel_x     = h_p0;
  assign vt.pixel_y     = v_p0;
  assign vt.hsync       = hsync_p0;
  assign vt.vsync       = vsync_p0;
  assign vt.blank       = blank_p0;
  assign vt.pix_req     = pix_req_p0;
  assign vt.line_start  = line_start_p0;
  assign vt.frame_start = frame_start_p0;
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator: successor to the fixed 640x480 VGA timing logic. It drives hsync, vsync, blank (display enable) and pixel coordinates to the DVI encoder interface. It also issues a lookahead pixel request so the pixel FIFO read side can be primed a programmable number of cycles before active video. It runs entirely in the pixel clock domain and exposes line/frame strobes for downstream frame-buffer logic.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CW, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1
- PREFETCH, 2, pix_req lead in cycles; legal range 0..H_FP+H_SYNC+H_BP-1
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  advance raster position when high; hold all state when low
- hsync  out  1  horizontal sync, active level HS_POL
- vsync  out  1  vertical sync, active level VS_POL
- blank  out  1  high during active video (display enable / FIFO read window), low in blanking
- pixel_x  out  CW  current horizontal position h
- pixel_y  out  CW  current vertical position v
- pix_req  out  1  high when position P+PREFETCH is active video
- line_start  out  1  one-cycle strobe, high while h==0
- frame_start  out  1  one-cycle strobe, high while h==0 and v==0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous. Line order: active, FP, sync, BP.
- Position P=(h,v). Each enabled edge: h increments; at H_TOTAL-1, h wraps to 0 and v increments; at (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- All outputs are registered functions of P. They change only on enabled edges and are consistent with P as shown on pixel_x/pixel_y.
- blank = (h<H_ACTIVE) && (v<V_ACTIVE).
- hsync active iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
- vsync active iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC. vsync edges coincide with h==0.
- Lookahead: h' = h+PREFETCH.
  - If h' ≥ H_TOTAL: wrap h' by subtracting H_TOTAL and use v' = v+1 mod V_TOTAL.
  - Otherwise v' = v.
  - pix_req = (h'<H_ACTIVE) && (v'<V_ACTIVE).
- pix_req is exactly blank shifted PREFETCH cycles earlier, including across the line and frame wrap. The count of pix_req-high cycles per frame equals H_ACTIVE*V_ACTIVE.
- PREFETCH=0: pix_req is identical to blank.
- enable low: P and all outputs, including strobes, hold their values.

## Timing
- Reset (async assert, any cycle, including mid-line):
  - P=(H_ACTIVE, V_TOTAL-1), i.e. start of front porch on the last line.
  - Output values: hsync=~HS_POL, vsync=~VS_POL, blank=0, pix_req=0, line_start=0, frame_start=0, pixel_x=H_ACTIVE, pixel_y=V_TOTAL-1.
- Reset release: the first enabled edge moves P to (H_ACTIVE+1, V_TOTAL-1).
- After reset release:
  - frame_start and the first blank=1 occur after H_TOTAL-H_ACTIVE enabled edges (160 at defaults).
  - The first pix_req occurs PREFETCH edges earlier, so frame 0 is fully prefetched.
- Output latency from P to outputs: 0 cycles as observed; outputs are registered and computed from the next position.
- Frame period: H_TOTAL*V_TOTAL enabled cycles (420000 at defaults).

## Configuration
- VTG_CSYNC_EN defined:
  - Adds port comp_sync (out, 1).
  - comp_sync is asserted at level HS_POL when (hsync active) XOR (vsync active); otherwise it sits at ~HS_POL.
  - It is registered like the other outputs; reset value ~HS_POL.
- VTG_CSYNC_EN undefined: comp_sync port and its logic are absent; all other behaviour is unchanged.

## Test plan
- Reset then free-run, defaults:
  - First frame_start occurs 160 edges after release.
  - Frame period is 420000 edges.
  - Per frame: 307200 blank-high cycles and 307200 pix_req-high cycles.
- Defaults, one line:
  - hsync low for h=656..751.
  - blank high for h=0..639.
  - pix_req high for h=798..799 of the previous line and h=0..637.
- Line 479 to 480 boundary, PREFETCH=2:
  - pix_req drops at h=638 of v=479 and stays low through v=524 until h=798.
  - vsync low exactly for v=490..491.
- Small config (H 8/2/2/2, V 4/1/1/1, PREFETCH=3, HS_POL=1):
  - Check every output against a reference model over 3 frames.
  - Check the h'/v' wrap at the last line.
- Toggle enable low for 5 cycles mid-active and mid-sync: all outputs frozen; resume with no lost or duplicated position.
- Assert rst mid-line, then with VTG_CSYNC_EN defined:
  - Immediately after assertion, outputs equal the reset values.
  - comp_sync is active during hsync only outside vsync, and during vsync only outside hsync.
